// File: rtl/program_memory_if.sv
// ---------------------------------------------------------------------------
// program_memory_if
//
// Bundles the CPU read/write port, the host program-loader stream and the
// hold/done status lines of program_memory.
//
// Signals (direction as seen by the memory, i.e. the slave modport):
//   rd_en      in   CPU read request
//   rd_addr    in   CPU read address
//   rd_data    out  registered read data (1-cycle latency)
//   wr_en      in   CPU write request
//   wr_addr    in   CPU write address
//   wr_data    in   CPU write data, only looked at while wr_en=1
//   load_start in   host pulse: begin a program load at address 0
//   load_valid in   host byte valid
//   load_data  in   host byte
//   load_last  in   marks the final byte of a load (with load_valid)
//   load_ready out  loader accepts a byte this cycle
//   cpu_hold   out  keeps the execution unit in reset
//   load_done  out  one-cycle pulse when a load completes
//
// Modports: master = CPU/host side, slave = memory side.
// ---------------------------------------------------------------------------
interface program_memory_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 load_start;
  logic                 load_valid;
  logic [DATA_BITS-1:0] load_data;
  logic                 load_last;
  logic                 load_ready;
  logic                 cpu_hold;
  logic                 load_done;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output load_start, load_valid, load_data, load_last,
    input  rd_data, load_ready, cpu_hold, load_done
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  load_start, load_valid, load_data, load_last,
    output rd_data, load_ready, cpu_hold, load_done
  );
endinterface

// File: rtl/program_memory.sv
// ---------------------------------------------------------------------------
// program_memory
//
// Byte-wide program/data memory for the execution unit. Serves a synchronous
// CPU read port (1-cycle latency, read-first on address collision) and a CPU
// write port, owns a host-facing program loader that streams bytes into the
// array from address 0 while the CPU is held, and drives cpu_hold, which the
// top level ORs into the execution unit's reset.
//
// Ports:
//   clk    in  clock
//   reset  in  asynchronous, active-high reset
//   bus    program_memory_if.slave: CPU port, loader stream, hold/done status
//
// Parameters:
//   ADDR_BITS  address width, depth = 2**ADDR_BITS bytes
//   DATA_BITS  data width
//
// Build option:
//   PROGRAM_MEMORY_CLEAR_EN  when defined, the whole array is written with 0
//                            after every reset before the CPU is released
//                            (hold lasts 2**ADDR_BITS+1 cycles). When not
//                            defined, the array keeps its contents across
//                            reset and the CPU is released after 1 cycle.
//
// States: INIT -> (CLEAR ->) RUN <-> LOAD. The array itself is never reset;
// only the control registers and rd_data are.
// ---------------------------------------------------------------------------
module program_memory #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  program_memory_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
`ifdef PROGRAM_MEMORY_CLEAR_EN
    CLEAR = 2'd1,
`endif
    RUN   = 2'd2,
    LOAD  = 2'd3
  } state_e;

  // Storage array: no reset, written from a single port shared by the CPU,
  // the loader and the clear sweep (only one of them is active per state).
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  state_e               state_q,      state_d;
  logic [ADDR_BITS-1:0] ptr_q,        ptr_d;
  logic [DATA_BITS-1:0] rd_data_q,    rd_data_d;
  logic                 cpu_hold_q,   cpu_hold_d;
  logic                 load_ready_q, load_ready_d;
  logic                 load_done_q,  load_done_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 load_accept;

  // The registered ready already encodes "in LOAD"; qualifying with the
  // state as well keeps a stray ready from ever writing outside LOAD.
  assign load_accept = (state_q == LOAD) && load_ready_q && bus.load_valid;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rd_data_d   = rd_data_q;
    load_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = '0;

    case (state_q)
      INIT: begin
`ifdef PROGRAM_MEMORY_CLEAR_EN
        state_d = CLEAR;
        ptr_d   = '0;
`else
        state_d = RUN;
`endif
      end

`ifdef PROGRAM_MEMORY_CLEAR_EN
      CLEAR: begin
        // One byte per cycle; the pointer wraps back to 0 on the last one.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
`endif

      RUN: begin
        // Read samples the array before this edge's write lands, so an
        // address collision returns the old byte.
        if (bus.rd_en) begin
          rd_data_d = mem_q[bus.rd_addr];
        end
        // wr_data may float when wr_en is low, so it is only muxed in here.
        if (bus.wr_en) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wr_addr;
          mem_wdata = bus.wr_data;
        end
        // The CPU access in the load_start cycle is still served above.
        if (bus.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end

      LOAD: begin
        // CPU port and load_start are ignored; rd_data holds.
        if (load_accept) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = bus.load_data;
          ptr_d     = ptr_q + 1'b1;
          // A full-array load ends on its own even without load_last.
          if (bus.load_last || (ptr_q == LAST_ADDR)) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    cpu_hold_d   = (state_d != RUN);
    load_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      rd_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rd_data_q    <= rd_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.load_ready = load_ready_q;
  assign bus.load_done  = load_done_q;

endmodule

// File: tb/tb_program_memory.sv
module tb_program_memory;
  localparam int AB    = 8;
  localparam int DB    = 8;
  localparam int DEPTH = 256;
`ifdef PROGRAM_MEMORY_CLEAR_EN
  localparam bit CLR  = 1'b1;
  localparam int BOOT = 257;
`else
  localparam bit CLR  = 1'b0;
  localparam int BOOT = 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  program_memory_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  program_memory #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [DEPTH];
  bit         m_kn  [DEPTH];
  logic [7:0] m_rd;
  bit         m_rd_kn;
  bit         m_hold, m_ready, m_done, m_loading;
  int         m_boot_left;
  int         m_lptr;

  task automatic model_reset();
    m_boot_left = BOOT;
    m_rd = 8'h00; m_rd_kn = 1'b1;
    m_hold = 1'b1; m_ready = 1'b0; m_done = 1'b0; m_loading = 1'b0;
    m_lptr = 0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (m_boot_left > 0) begin
      int k;
      k = BOOT - m_boot_left;  // edges already taken since reset release
      if (CLR && k >= 1) begin
        m_mem[k-1] = 8'h00; m_kn[k-1] = 1'b1;
      end
      m_boot_left--;
    end else if (m_loading) begin
      if (bus.load_valid) begin
        m_mem[m_lptr] = bus.load_data; m_kn[m_lptr] = 1'b1;
        if (bus.load_last || m_lptr == DEPTH-1) begin
          m_loading = 1'b0; m_done = 1'b1;
        end
        m_lptr = (m_lptr + 1) % DEPTH;
      end
    end else begin
      if (bus.rd_en) begin
        m_rd = m_mem[bus.rd_addr]; m_rd_kn = m_kn[bus.rd_addr];
      end
      if (bus.wr_en) begin
        m_mem[bus.wr_addr] = bus.wr_data; m_kn[bus.wr_addr] = 1'b1;
      end
      if (bus.load_start) begin
        m_loading = 1'b1; m_lptr = 0;
      end
    end
    m_hold  = (m_boot_left > 0) || m_loading;
    m_ready = m_loading;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_kn[i] = 1'b0; end
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_hold", int'(bus.cpu_hold), int'(m_hold));
      check("load_ready", int'(bus.load_ready), int'(m_ready));
      check("load_done", int'(bus.load_done), int'(m_done));
      if (m_rd_kn) check("rd_data", int'(bus.rd_data), int'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rd_en = 0; bus.rd_addr = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    bus.rd_en = 1; bus.rd_addr = a;
    tick();
    bus.rd_en = 0;
    d = bus.rd_data;
  endtask

  task automatic wait_run(output int cycles);
    cycles = 0;
    while (bus.cpu_hold && cycles < 400) begin
      tick(); cycles++;
    end
    if (bus.cpu_hold) check("wait_run_timeout", 1, 0);
  endtask

  logic [7:0] rv;
  int         cnt, dones;
  logic [7:0] prog [4];

  initial begin
    idle();
    #1 chk_en = 1'b1;
    // reset values
    repeat (3) @(negedge clk);
    check("rst_rd_data", int'(bus.rd_data), 0);
    check("rst_cpu_hold", int'(bus.cpu_hold), 1);
    check("rst_load_ready", int'(bus.load_ready), 0);
    check("rst_load_done", int'(bus.load_done), 0);
    reset = 1'b0;
    wait_run(cnt);
    check("hold_release_cycles", cnt, BOOT);

`ifdef PROGRAM_MEMORY_CLEAR_EN
    cpu_read(8'h00, rv); check("clr_rd_00", int'(rv), 0);
    cpu_read(8'h7F, rv); check("clr_rd_7F", int'(rv), 0);
    cpu_read(8'hFF, rv); check("clr_rd_FF", int'(rv), 0);
`endif

    // write then read, then read-first collision
    cpu_write(8'h10, 8'hA5);
    cpu_read(8'h10, rv); check("wr_rd_A5", int'(rv), 8'hA5);
    bus.rd_en = 1; bus.rd_addr = 8'h10; bus.wr_en = 1; bus.wr_addr = 8'h10; bus.wr_data = 8'h3C;
    tick();
    idle();
    check("collide_old", int'(bus.rd_data), 8'hA5);
    cpu_read(8'h10, rv); check("collide_new", int'(rv), 8'h3C);

    // load with toggling valid
    prog[0] = 8'h91; prog[1] = 8'h05; prog[2] = 8'h00; prog[3] = 8'h00;
    bus.load_start = 1; tick(); bus.load_start = 0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      bus.load_valid = (i % 2 == 0);
      bus.load_data  = prog[i/2];
      bus.load_last  = (i % 2 == 0) && (i/2 == 3);
      tick();
      if (bus.load_done) dones++;
    end
    idle();
    tick();
    if (bus.load_done) dones++;
    check("load_done_pulses", dones, 1);
    check("load_hold_released", int'(bus.cpu_hold), 0);
    for (int i = 0; i < 4; i++) begin
      cpu_read(8'(i), rv); check("load_readback", int'(rv), int'(prog[i]));
    end

    // CPU access during LOAD is ignored
    cpu_write(8'h20, 8'h5A);
    cpu_read(8'h10, rv);
    bus.load_start = 1; tick(); bus.load_start = 0;
    bus.wr_en = 1; bus.wr_addr = 8'h20; bus.wr_data = 8'h77;
    bus.rd_en = 1; bus.rd_addr = 8'h20;
    tick();
    check("rd_hold_in_load", int'(bus.rd_data), 8'h3C);
    idle();
    bus.load_valid = 1; bus.load_data = 8'hEE; bus.load_last = 1;
    tick();
    idle();
    cpu_read(8'h20, rv); check("wr_ignored_in_load", int'(rv), 8'h5A);

    // full-array load, no load_last
    bus.load_start = 1; tick(); bus.load_start = 0;
    dones = 0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.load_valid = 1; bus.load_data = 8'(a) ^ 8'hFF; bus.load_last = 0;
      tick();
      if (bus.load_done) dones++;
    end
    idle();
    tick();
    if (bus.load_done) dones++;
    check("wrap_done_pulses", dones, 1);
    check("wrap_hold_released", int'(bus.cpu_hold), 0);
    cpu_read(8'h00, rv); check("wrap_rd_00", int'(rv), 8'hFF);
    cpu_read(8'h10, rv); check("wrap_rd_10", int'(rv), 8'hEF);
    cpu_read(8'hFF, rv); check("wrap_rd_FF", int'(rv), 8'h00);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 2000; c++) begin
      bus.rd_en      = $urandom_range(0, 1);
      bus.rd_addr    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      bus.wr_en      = ($urandom_range(0, 2) == 0);
      bus.wr_addr    = ($urandom_range(0, 1) == 0) ? bus.rd_addr : 8'($urandom_range(0, 31));
      bus.wr_data    = 8'($urandom);
      bus.load_start = ($urandom_range(0, 40) == 0);
      bus.load_valid = $urandom_range(0, 1);
      bus.load_data  = 8'($urandom);
      bus.load_last  = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    // finish any load left open by the random phase
    bus.load_valid = 1; bus.load_last = 1; bus.load_data = 8'h42;
    cnt = 0;
    while (bus.cpu_hold && cnt < 400) begin tick(); cnt++; end
    if (bus.cpu_hold) check("drain_timeout", 1, 0);
    idle();
    cpu_read(8'h10, rv);

    // reset in the middle of a load
    bus.load_start = 1; tick(); bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 8'h11; tick();
    bus.load_data = 8'h22; tick();
    bus.load_data = 8'h33;
    #2 reset = 1'b1;
    #1;
    check("async_rd_data", int'(bus.rd_data), 0);
    check("async_cpu_hold", int'(bus.cpu_hold), 1);
    check("async_load_ready", int'(bus.load_ready), 0);
    check("async_load_done", int'(bus.load_done), 0);
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    cnt = 0;
    while (bus.cpu_hold && cnt < 400) begin
      tick(); cnt++;
      if (bus.load_done) dones++;
    end
    if (bus.cpu_hold) check("reload_timeout", 1, 0);
    check("abort_release_cycles", cnt, BOOT);
    check("abort_no_done", dones, 0);
    cpu_read(8'h00, rv); check("abort_byte0", int'(rv), CLR ? 0 : 8'h11);
    cpu_read(8'h01, rv); check("abort_byte1", int'(rv), CLR ? 0 : 8'h22);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/program_memory.md
# program_memory

Byte-wide program/data memory feeding the execution unit. Serves the CPU's synchronous read port (1-cycle latency) and write port, and drives `cpu_hold`, which the top level ORs into the execution unit's reset. Owns a host-facing program loader that streams bytes into memory while the CPU is held. Optionally clears the whole array after reset.

## Interface
Parameters:
- `ADDR_BITS`, 8, address width; depth = 2^ADDR_BITS bytes.
- `DATA_BITS`, 8, data width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rd_en`  in  1  CPU read request.
- `rd_addr`  in  ADDR_BITS  CPU read address.
- `rd_data`  out  DATA_BITS  registered read data.
- `wr_en`  in  1  CPU write request.
- `wr_addr`  in  ADDR_BITS  CPU write address.
- `wr_data`  in  DATA_BITS  CPU write data; sampled only when `wr_en`=1, may be Z otherwise.
- `load_start`  in  1  host pulse: begin program load at address 0.
- `load_valid`  in  1  host byte valid.
- `load_data`  in  DATA_BITS  host byte.
- `load_last`  in  1  qualifies the final byte, with `load_valid`.
- `load_ready`  out  1  loader accepts a byte this cycle.
- `cpu_hold`  out  1  keeps the execution unit in reset.
- `load_done`  out  1  one-cycle pulse when a load completes.

## Operation
- States: `INIT`, `CLEAR`, `RUN`, `LOAD`.
- Reset values: state=`INIT`, `rd_data`=0, `cpu_hold`=1, `load_ready`=0, `load_done`=0, pointer=0.
- Memory contents are not reset, except by `CLEAR`.
- `INIT` → `CLEAR` on the next clock if the clear feature is compiled in; otherwise `INIT` → `RUN`.
- `CLEAR`:
  - Writes 0 to address pointer, then increments the pointer.
  - After writing address 2^ADDR_BITS−1, the pointer wraps to 0 and the state goes to `RUN`.
- `RUN`:
  - `cpu_hold`=0.
  - `rd_en`=1: `rd_data` ← mem[`rd_addr`] at the clock edge.
  - `rd_en`=0: `rd_data` holds its previous value.
  - `wr_en`=1: mem[`wr_addr`] ← `wr_data`.
  - Read and write in the same cycle are both served.
  - Same address in the same cycle: read-first, so `rd_data` returns the old byte.
- `RUN` + `load_start`=1 → `LOAD`:
  - Pointer ← 0, `cpu_hold`=1 from the next cycle.
  - A CPU access in that same cycle is still served.
- `LOAD`:
  - `load_ready`=1.
  - On `load_valid`&`load_ready`: mem[pointer] ← `load_data`, pointer++.
  - Exit to `RUN` when a byte with `load_last`=1 is accepted, or when a byte at address 2^ADDR_BITS−1 is accepted (pointer wraps to 0).
  - On exit, `load_done` pulses for 1 cycle (asserted in the first `RUN` cycle).
- In `CLEAR` and `LOAD`:
  - CPU `rd_en`/`wr_en` are ignored and `rd_data` holds.
  - `load_start` is ignored; a `LOAD` is never restarted mid-load.
- Reset mid-`CLEAR` or mid-`LOAD` aborts immediately. Partially written bytes stay; flow restarts at `INIT`.

## Timing
- Read latency: 1 cycle. Address presented at edge N produces data valid after edge N, usable at edge N+1. This matches the execution unit's two-cycle fetch.
- Write takes effect at the edge where `wr_en` is sampled; a read of that address at the next edge returns the new byte.
- `cpu_hold` is registered and deasserts on the first `RUN` cycle.
- Without clear: hold is released 1 cycle after reset is deasserted.
- With clear: hold is released 2^ADDR_BITS+1 cycles after reset is deasserted.
- Loader throughput: 1 byte/cycle. `load_ready` does not depend combinationally on `load_valid`.

## Configuration
- `PROGRAM_MEMORY_CLEAR_EN` defined:
  - `CLEAR` state and its logic are compiled in.
  - Every byte reads 0 after reset.
- Not defined:
  - No `CLEAR` state.
  - Memory keeps its prior or initial-file contents across reset.
  - `INIT` → `RUN` directly.

## Test plan
- Clear enabled: reset, then count cycles → `cpu_hold` falls exactly 257 cycles after reset deassert (ADDR_BITS=8); reads of 0x00, 0x7F, 0xFF return 0x00.
- `RUN`: write 0xA5 to 0x10, then read 0x10 next cycle → `rd_data`=0xA5 one edge after the read. Same-cycle read+write to 0x10 with data 0x3C → `rd_data`=0xA5; the following read returns 0x3C.
- Load: `load_start`, then stream 0x91,0x05,0x00,0x00 with `load_last` on the 4th byte, `load_valid` toggling every other cycle → mem[0..3] hold those bytes; one `load_done` pulse; `cpu_hold`=1 throughout, then 0.
- Load wrap: 256 bytes, value = address XOR 0xFF, no `load_last` → exits after byte 255, pointer=0; readback matches.
- CPU access during `LOAD`: `wr_en` to 0x20 with 0x77 → mem[0x20] unchanged; `rd_data` holds.
- Reset asserted at byte 2 of a load → outputs return to reset values asynchronously; after `RUN`, bytes 0–1 are retained and `load_done` was never pulsed.
